conv3x3_serial_mac: RTL and testbench

- Serial multiply-accumulate stage for one 3x3 convolution window.
- Sits directly downstream of the 9:1 tap muxes: one mux selects the pixel, one selects the weight, and both share a select bus driven by this block.
- On an accepted start it steps `sel` through 0..8, multiplies the selected pixel by the selected weight, and accumulates the nine products onto a bias.
- The finished sum is presented on a valid/ready result port.

---
 rtl/conv3x3_serial_mac.sv | 77 +++++++
 tb/tb_conv3x3_serial_mac.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_serial_mac.sv
// Serial 3x3 MAC: steps the tap select 0..8, accumulates pix*wgt onto a bias.
// Latency: start accepted at edge N, result valid after edge N+9.
// Backpressure: holds result and refuses new starts until res_ready.
module conv3x3_serial_mac #(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic signed [ACC_WIDTH-1:0] bias_in,
  input  logic signed [BIT_DEPTH-1:0] pix_in,
  input  logic signed [BIT_DEPTH-1:0] wgt_in,
  output logic        [3:0]           sel,
  output logic                        busy,
  output logic signed [ACC_WIDTH-1:0] res_data,
  output logic                        res_valid,
  input  logic                        res_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [2*BIT_DEPTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc_next;

  // Both operands are signed, so the full-width product cannot overflow.
  assign prod     = pix_in * wgt_in;
  assign prod_ext = {{(ACC_WIDTH-2*BIT_DEPTH){prod[2*BIT_DEPTH-1]}}, prod};
  assign acc_next = acc + prod_ext;

  assign start_ready = (state == IDLE);
  assign busy        = (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc   <= bias_in;
            sel   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (sel == 4'd8) begin
            res_data  <= acc_next;
            res_valid <= 1'b1;
            sel       <= '0;
            state     <= DONE;
          end else begin
            sel <= sel + 4'd1;
          end
        end
        DONE: begin
          // Result stays frozen here; any start request waits for the handshake.
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_serial_mac.sv
// Directed bench for conv3x3_serial_mac; the 9:1 tap muxes are modelled by
// per-tap lookup tables indexed by the DUT's sel output.
module tb_conv3x3_serial_mac;

  localparam int BD = 8;
  localparam int AW = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_valid;
  logic                 start_ready;
  logic signed [AW-1:0] bias_in;
  logic signed [BD-1:0] pix_in;
  logic signed [BD-1:0] wgt_in;
  logic        [3:0]    sel;
  logic                 busy;
  logic signed [AW-1:0] res_data;
  logic                 res_valid;
  logic                 res_ready;

  logic signed [BD-1:0] pix_tab [16];
  logic signed [BD-1:0] wgt_tab [16];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign pix_in = pix_tab[sel];
  assign wgt_in = wgt_tab[sel];

  conv3x3_serial_mac #(.BIT_DEPTH(BD), .ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .bias_in     (bias_in),
    .pix_in      (pix_in),
    .wgt_in      (wgt_in),
    .sel         (sel),
    .busy        (busy),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  task automatic set_taps(input logic signed [BD-1:0] p, input logic signed [BD-1:0] w);
    for (int i = 0; i < 16; i++) begin
      pix_tab[i] = p;
      wgt_tab[i] = w;
    end
  endtask

  // One full window with res_ready high; checks sel stepping, busy length,
  // result value/timing and the return to IDLE.
  task automatic run_window(input logic signed [AW-1:0] b, input logic signed [AW-1:0] expv,
                            input string name);
    @(negedge clk);
    res_ready   = 1'b1;
    start_valid = 1'b1;
    bias_in     = b;
    vectors++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready got %b exp 1", name, start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
    bias_in     = ~b;  // must not disturb the window already accepted
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if ({sel, busy, start_ready} !== {4'(i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s step%0d sel/busy/start_ready got %0d/%b/%b exp %0d/1/0",
                 name, i, sel, busy, start_ready, i);
      end
    end
    @(negedge clk);
    vectors++;
    if ({res_valid, busy, start_ready, sel} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL %s done valid/busy/start_ready/sel got %b/%b/%b/%0d exp 1/0/0/0",
               name, res_valid, busy, start_ready, sel);
    end
    vectors++;
    if (res_data !== expv) begin
      errors++;
      $display("FAIL %s res_data got %0d (%h) exp %0d (%h)", name, res_data, res_data, expv, expv);
    end
    @(negedge clk);
    vectors++;
    if ({res_valid, start_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s after handshake valid/start_ready got %b/%b exp 0/1",
               name, res_valid, start_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; bias_in = '0;
    set_taps(8'sd0, 8'sd0);
    repeat (3) @(negedge clk);
    vectors++;
    if ({sel, busy, start_ready, res_valid, res_data} !== {4'd0, 1'b0, 1'b1, 1'b0, 20'd0}) begin
      errors++;
      $display("FAIL reset sel/busy/start_ready/valid/data got %0d/%b/%b/%b/%0d exp 0/0/1/0/0",
               sel, busy, start_ready, res_valid, res_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_unit;
    set_taps(8'sd1, 8'sd1);
    run_window(20'sd0, 20'sd9, "unit");
  endtask

  task automatic test_neg_bias;
    for (int i = 0; i < 16; i++) begin
      pix_tab[i] = BD'(i + 1);
      wgt_tab[i] = -8'sd1;
    end
    run_window(20'sd100, 20'sd55, "neg_bias");
  endtask

  task automatic test_extremes;
    set_taps(-8'sd128, -8'sd128);
    run_window(20'sd0, 20'h24000, "ext_negneg");
    set_taps(-8'sd128, 8'sd127);
    run_window(20'sd0, 20'hDC480, "ext_negpos");
  endtask

  task automatic test_backpressure;
    logic signed [AW-1:0] held;
    int guard;
    set_taps(8'sd3, 8'sd4);
    @(negedge clk);
    res_ready = 1'b0; start_valid = 1'b1; bias_in = 20'sd7;
    @(negedge clk);
    start_valid = 1'b0;
    guard = 0;
    while (res_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 20'sd115) begin
      errors++;
      $display("FAIL bp_result valid/data got %b/%0d exp 1/115", res_valid, res_data);
    end
    held = 20'sd115;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({res_valid, res_data, start_ready, sel, busy} !== {1'b1, held, 1'b0, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall%0d valid/data/start_ready/sel/busy got %b/%0d/%b/%0d/%b exp 1/%0d/0/0/0",
                 i, res_valid, res_data, start_ready, sel, busy, held);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({res_valid, start_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release valid/start_ready got %b/%b exp 0/1", res_valid, start_ready);
    end
    bias_in = 20'sd1;
    @(negedge clk);
    start_valid = 1'b0;
    vectors++;
    if ({busy, sel} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL bp_restart busy/sel got %b/%0d exp 1/0", busy, sel);
    end
    guard = 0;
    while (res_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 20'sd109) begin
      errors++;
      $display("FAIL bp_second valid/data got %b/%0d exp 1/109", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int guard;
    set_taps(8'sd5, 8'sd5);
    @(negedge clk);
    res_ready = 1'b1; start_valid = 1'b1; bias_in = 20'sd0;
    @(negedge clk);
    start_valid = 1'b0;
    guard = 0;
    while (sel !== 4'd4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (sel !== 4'd4) begin
      errors++;
      $display("FAIL rst_mid reach sel got %0d exp 4", sel);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({sel, busy, start_ready, res_valid, res_data} !== {4'd0, 1'b0, 1'b1, 1'b0, 20'd0}) begin
      errors++;
      $display("FAIL rst_mid async sel/busy/start_ready/valid/data got %0d/%b/%b/%b/%0d exp 0/0/1/0/0",
               sel, busy, start_ready, res_valid, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    set_taps(8'sd2, 8'sd3);
    run_window(-20'sd10, 20'sd44, "rst_mid_after");
  endtask

  task automatic test_back_to_back;
    int cnt;
    set_taps(8'sd1, 8'sd2);
    @(negedge clk);
    res_ready = 1'b1; start_valid = 1'b1; bias_in = 20'sd0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b first start busy got %b exp 1", busy);
    end
    cnt = 0;
    while (busy !== 1'b0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    while (busy !== 1'b1 && cnt < 30) begin
      vectors++;
      if (res_valid === 1'b1 && res_data !== 20'sd18) begin
        errors++;
        $display("FAIL b2b res_data got %0d exp 18", res_data);
      end
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (cnt !== 11) begin
      errors++;
      $display("FAIL b2b period got %0d exp 11", cnt);
    end
    start_valid = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unit();
    test_neg_bias();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
